// File: rtl/output_control_pkg.sv
// Shared router definitions: default sizes, output FSM encoding and the
// grant-decoding helpers also used by the arbiter.
package output_control_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NUM_IN_DEF = 4;
  localparam int MAX_IN     = 32;
  localparam int IDX_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Exactly one bit set; an all-zero vector is not one-hot.
  function automatic logic is_onehot(input logic [MAX_IN-1:0] v);
    return (v != '0) && ((v & (v - MAX_IN'(1))) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_IN-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_IN; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/output_control_onehot_mux.sv
// Selects one DATA_W-wide slice of the concatenated input-buffer bus.
module output_control_onehot_mux #(
  parameter int DATA_W = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [NUM_IN*DATA_W-1:0] data_i,
  output logic [DATA_W-1:0]        data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (SEL_W'(i) == sel_i) data_o = data_i[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/output_control.sv
// Read-side controller for one router output port: reads the granted input
// buffer, clears its full flag, and hands the flit to the downstream link.
module output_control
  import output_control_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        grant,
  input  logic [NUM_IN-1:0]        isfull,
  input  logic [NUM_IN*DATA_W-1:0] buf_data,
  input  logic                     out_ready,
  output logic [NUM_IN-1:0]        read_en,
  output logic [NUM_IN-1:0]        clear_flag,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     done,
  output logic                     busy,
  output logic                     grant_err,
  output logic [CNT_W-1:0]         pkt_count
);

  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  state_e              state_q;
  logic [SEL_W-1:0]    sel_q;
  logic [SEL_W-1:0]    sel_d;
  logic [DATA_W-1:0]   hold_q;
  logic [DATA_W-1:0]   mux_data;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                err_q;
  logic [MAX_IN-1:0]   grant_ext;
  logic                grant_1h;
  logic                grant_multi;
  logic                grant_hit;
  logic [NUM_IN-1:0]   sel_dec;

  assign grant_ext   = MAX_IN'(grant);
  assign grant_1h    = is_onehot(grant_ext);
  assign grant_multi = (grant != '0) && !grant_1h;
  assign grant_hit   = (grant & isfull) != '0;
  assign sel_d       = SEL_W'(onehot_to_idx(grant_ext));
  assign cnt_d       = cnt_q + CNT_W'(1);
  assign sel_dec     = NUM_IN'(1) << sel_q;

  output_control_onehot_mux #(
    .DATA_W (DATA_W),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .sel_i  (sel_q),
    .data_i (buf_data),
    .data_o (mux_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_multi) begin
            err_q <= 1'b1;
          end else if (grant_1h && grant_hit) begin
            sel_q   <= sel_d;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          hold_q  <= mux_data;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            cnt_q   <= cnt_d;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes and status decode only from state and the latched selection.
  assign read_en    = (state_q == ST_LOAD) ? sel_dec : '0;
  assign clear_flag = (state_q == ST_LOAD) ? sel_dec : '0;
  assign out_valid  = (state_q == ST_SEND);
  assign out_data   = hold_q;
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign grant_err  = err_q;
  assign pkt_count  = cnt_q;

endmodule

// File: tb/tb_output_control.sv
// Scoreboarded bench for output_control: flits are queued when a transfer is
// granted and checked as the downstream link accepts them.
module tb_output_control;

  localparam int DATA_W = 8;
  localparam int NUM_IN = 4;
  localparam int CNT_W  = 4;

  logic                     clk;
  logic                     reset;
  logic [NUM_IN-1:0]        grant;
  logic [NUM_IN-1:0]        isfull;
  logic [NUM_IN*DATA_W-1:0] buf_data;
  logic                     out_ready;
  logic [NUM_IN-1:0]        read_en;
  logic [NUM_IN-1:0]        clear_flag;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     done;
  logic                     busy;
  logic                     grant_err;
  logic [CNT_W-1:0]         pkt_count;

  int unsigned      n_vec = 0;
  int unsigned      n_err = 0;
  logic [7:0]       sb[$];
  logic [CNT_W-1:0] exp_cnt;

  output_control #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .grant      (grant),
    .isfull     (isfull),
    .buf_data   (buf_data),
    .out_ready  (out_ready),
    .read_en    (read_en),
    .clear_flag (clear_flag),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .done       (done),
    .busy       (busy),
    .grant_err  (grant_err),
    .pkt_count  (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Negedge monitor: a handshake seen here fires on the coming rising edge.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk("sb_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
    end
  end

  // One flit from buffer idx; optional stall cycles and grant disturbance in SEND.
  task automatic xfer(input int idx, input logic [7:0] d, input int stall, input bit disturb);
    isfull[idx]             = 1'b1;
    buf_data[idx*8 +: 8]    = d;
    grant                   = NUM_IN'(1) << idx;
    out_ready               = (stall == 0);
    sb.push_back(d);
    tick();
    chk("load_rd", {28'd0, read_en}, 32'(NUM_IN'(1) << idx));
    chk("load_clr", {28'd0, clear_flag}, 32'(NUM_IN'(1) << idx));
    grant       = '0;
    isfull[idx] = 1'b0;
    tick();
    chk("send_vld", {31'd0, out_valid}, 32'd1);
    chk("send_data", {24'd0, out_data}, {24'd0, d});
    if (disturb) begin
      grant     = 4'b1000;
      isfull[3] = 1'b1;
    end
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_vld", {31'd0, out_valid}, 32'd1);
      chk("stall_data", {24'd0, out_data}, {24'd0, d});
      chk("stall_rd", {28'd0, read_en}, 32'd0);
    end
    grant     = '0;
    isfull[3] = 1'b0;
    out_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk("done", {31'd0, done}, 32'd1);
    chk("done_vld", {31'd0, out_valid}, 32'd0);
    chk("cnt", 32'(pkt_count), 32'(exp_cnt));
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    grant     = '0;
    isfull    = '0;
    buf_data  = '0;
    out_ready = 1'b1;
    exp_cnt   = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_cnt", 32'(pkt_count), 32'd0);
    chk("rst_err", {31'd0, grant_err}, 32'd0);
    chk("rst_rd", {28'd0, read_en}, 32'd0);
    reset = 1'b1;
    tick();

    // Basic transfer, then backpressure, both from buffer 2.
    xfer(2, 8'hA5, 0, 1'b0);
    chk("basic_cnt", 32'(pkt_count), 32'd1);
    xfer(2, 8'hA5, 5, 1'b0);
    chk("bp_cnt", 32'(pkt_count), 32'd2);

    // Grant to an empty buffer: no read until the flag rises.
    grant  = 4'b0001;
    isfull = 4'b0000;
    tick();
    chk("empty_busy", {31'd0, busy}, 32'd0);
    chk("empty_rd", {28'd0, read_en}, 32'd0);
    tick();
    chk("empty_busy2", {31'd0, busy}, 32'd0);
    xfer(0, 8'h3C, 0, 1'b0);

    // Multi-hot grant: error sticks, no read.
    grant  = 4'b0011;
    isfull = 4'b0011;
    tick();
    chk("multi_rd", {28'd0, read_en}, 32'd0);
    chk("multi_busy", {31'd0, busy}, 32'd0);
    chk("multi_err", {31'd0, grant_err}, 32'd1);
    grant  = '0;
    isfull = '0;
    tick();
    chk("err_sticky", {31'd0, grant_err}, 32'd1);
    xfer(1, 8'h5A, 0, 1'b0);
    chk("err_sticky2", {31'd0, grant_err}, 32'd1);

    // Grant moves to buffer 3 during SEND; original flit completes.
    xfer(2, 8'hC3, 3, 1'b1);

    // Asynchronous reset mid-SEND drops the flit.
    isfull[2]        = 1'b1;
    buf_data[23:16]  = 8'h77;
    grant            = 4'b0100;
    out_ready        = 1'b0;
    tick();
    grant  = '0;
    isfull = '0;
    tick();
    chk("pre_rst_vld", {31'd0, out_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_vld", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_data", {24'd0, out_data}, 32'd0);
    chk("arst_cnt", 32'(pkt_count), 32'd0);
    chk("arst_err", {31'd0, grant_err}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    exp_cnt = '0;
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();

    // Counter wrap with a 4-bit counter.
    for (int k = 1; k <= 17; k++) begin
      xfer(k % NUM_IN, 8'(k * 13 + 1), 0, 1'b0);
      if (k == 15) chk("wrap15", 32'(pkt_count), 32'd15);
      if (k == 16) chk("wrap16", 32'(pkt_count), 32'd0);
      if (k == 17) chk("wrap17", 32'(pkt_count), 32'd1);
    end

    tick();
    chk("sb_left", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
